// File: rtl/exp_int_pkg.sv
// Shared definitions for the exception/interrupt controller: FSM states,
// default sizing and a highest-set-bit helper used for priority and nesting.
package exp_int_pkg;

    localparam int NUM_SRC_DEF     = 3;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int MAX_SRC         = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    // Index of the highest set bit, or -1 when the vector is empty.
    function automatic int highest_idx(input logic [MAX_SRC-1:0] vec);
        int idx;
        idx = -1;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous interrupt line, followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module irq_sync_edge
    import exp_int_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // History resets low, so a line already high at release yields one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/exp_int_ctrl.sv
// Interrupt front end for CP0: latches pending edges, arbitrates eligible
// sources by priority, holds a one-hot request until Ack, tracks nesting.
module exp_int_ctrl
    import exp_int_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] IrqIn,
    input  logic [NUM_SRC-1:0] IrqMask,
    input  logic               GlobalBlock,
    input  logic               Ack,
    input  logic               Eret,
    output logic               ExpReq,
    output logic [NUM_SRC-1:0] ExpSrc,
    output logic [NUM_SRC-1:0] Pending,
    output logic [NUM_SRC-1:0] InService
);

    // One extra bit so that "no level" (-1) sorts below every index.
    localparam int LW = $clog2(NUM_SRC) + 1;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] exp_src_q, exp_src_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] win_onehot;
    logic [NUM_SRC-1:0] accept_vec;
    logic signed [LW-1:0] is_lvl;
    logic signed [LW-1:0] win_idx;

    for (genvar g = 0; g < NUM_SRC; g++) begin : gen_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .irq_i (IrqIn[g]),
            .rise_o(rise[g])
        );
    end

    always_comb begin
        eligible   = '0;
        win_onehot = '0;
        is_lvl     = LW'(highest_idx(MAX_SRC'(in_service_q)));
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_q[i] & IrqMask[i] & ~GlobalBlock
                          & ($signed(LW'(i)) > is_lvl);
        end
        win_idx = LW'(highest_idx(MAX_SRC'(eligible)));
        for (int i = 0; i < NUM_SRC; i++) begin
            win_onehot[i] = (win_idx == $signed(LW'(i)));
        end
    end

    assign accept_vec = ((state_q == REQ) && Ack) ? exp_src_q : '0;

    // A fresh edge on the source being accepted keeps it pending.
    always_comb begin
        pending_d    = (pending_q & ~accept_vec) | rise;
        in_service_d = in_service_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (Eret && (is_lvl == $signed(LW'(i)))) in_service_d[i] = 1'b0;
        end
        in_service_d = in_service_d | accept_vec;
    end

    always_comb begin
        state_d   = state_q;
        exp_src_d = exp_src_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    exp_src_d = win_onehot;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // Acceptance wins over a simultaneous mask/block withdrawal.
                if (Ack) begin
                    exp_src_d = '0;
                    state_d   = IDLE;
                end else if (GlobalBlock || ((exp_src_q & IrqMask) == '0)) begin
                    exp_src_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                exp_src_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_src_q    <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            exp_src_q    <= exp_src_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end

    assign ExpReq    = (state_q == REQ);
    assign ExpSrc    = exp_src_q;
    assign Pending   = pending_q;
    assign InService = in_service_q;

endmodule

// File: tb/tb_exp_int_ctrl.sv
// Bench for exp_int_ctrl: directed scenarios plus randomized traffic, checked
// against a behavioural model and a request scoreboard.
module tb_exp_int_ctrl;

    localparam int N = 3;
    localparam int S = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] IrqIn;
    logic [N-1:0] IrqMask;
    logic         GlobalBlock;
    logic         Ack;
    logic         Eret;
    logic         ExpReq;
    logic [N-1:0] ExpSrc;
    logic [N-1:0] Pending;
    logic [N-1:0] InService;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [N-1:0] m_pend;
    logic [N-1:0] m_is;
    logic [N-1:0] m_smp[$];
    bit           m_req;
    int           m_src;
    logic [N-1:0] exp_q[$];

    exp_int_ctrl #(
        .NUM_SRC    (N),
        .SYNC_STAGES(S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .IrqIn      (IrqIn),
        .IrqMask    (IrqMask),
        .GlobalBlock(GlobalBlock),
        .Ack        (Ack),
        .Eret       (Eret),
        .ExpReq     (ExpReq),
        .ExpSrc     (ExpSrc),
        .Pending    (Pending),
        .InService  (InService)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_is   = '0;
        m_req  = 1'b0;
        m_src  = -1;
        m_smp.delete();
        for (int i = 0; i < S + 1; i++) m_smp.push_back('0);
        exp_q.delete();
    endtask

    // One clock edge of the specified behaviour, computed from the rules.
    task automatic model_step();
        logic [N-1:0] rise;
        logic [N-1:0] pend_n;
        logic [N-1:0] is_n;
        int lvl;
        int top;
        bit acc;
        rise = m_smp[1] & ~m_smp[0];
        void'(m_smp.pop_front());
        m_smp.push_back(IrqIn);
        lvl = -1;
        for (int i = 0; i < N; i++) if (m_is[i]) lvl = i;
        top = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && IrqMask[i] && !GlobalBlock && (i > lvl)) top = i;
        acc    = m_req && Ack;
        pend_n = m_pend;
        if (acc) pend_n[m_src] = 1'b0;
        pend_n = pend_n | rise;
        is_n = m_is;
        if (Eret && lvl >= 0) is_n[lvl] = 1'b0;
        if (acc) is_n[m_src] = 1'b1;
        if (!m_req) begin
            if (top >= 0) begin
                m_req = 1'b1;
                m_src = top;
                exp_q.push_back(N'(1) << top);
            end
        end else if (Ack) begin
            m_req = 1'b0;
            m_src = -1;
        end else if (GlobalBlock || !IrqMask[m_src]) begin
            m_req = 1'b0;
            m_src = -1;
        end
        m_pend = pend_n;
        m_is   = is_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit           prev;
        logic [N-1:0] e_src;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                e_src = m_req ? (N'(1) << m_src) : '0;
                check("model_exp_req", 32'(ExpReq), 32'(m_req));
                check("model_exp_src", 32'(ExpSrc), 32'(e_src));
                check("model_pending", 32'(Pending), 32'(m_pend));
                check("model_in_service", 32'(InService), 32'(m_is));
                if (ExpReq && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_scoreboard: got request %b expected none", ExpSrc);
                    end else begin
                        check("req_scoreboard", 32'(ExpSrc), 32'(exp_q.pop_front()));
                    end
                end
                prev = ExpReq;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!ExpReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ExpReq) begin
            checks++;
            errors++;
            $display("FAIL %s: got ExpReq=0 after 20 cycles expected 1", name);
        end
    endtask

    task automatic pulse_ack();
        Ack = 1'b1;
        @(negedge clk);
        Ack = 1'b0;
    endtask

    task automatic pulse_eret();
        Eret = 1'b1;
        @(negedge clk);
        Eret = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        rst         = 1'b1;
        IrqIn       = '0;
        IrqMask     = 3'b111;
        GlobalBlock = 1'b0;
        Ack         = 1'b0;
        Eret        = 1'b0;
        idle(3);
        rst = 1'b0;
        check("rst_exp_req", 32'(ExpReq), 32'd0);
        check("rst_exp_src", 32'(ExpSrc), 32'd0);
        check("rst_pending", 32'(Pending), 32'd0);
        check("rst_in_service", 32'(InService), 32'd0);

        // Single source latency.
        IrqIn = 3'b001;
        idle(2);
        check("lat_pend_e1", 32'(Pending), 32'b000);
        idle(1);
        check("lat_pend_e2", 32'(Pending), 32'b001);
        check("lat_req_e2", 32'(ExpReq), 32'd0);
        idle(1);
        check("lat_req_e3", 32'(ExpReq), 32'd1);
        check("lat_src_e3", 32'(ExpSrc), 32'b001);
        pulse_ack();
        check("ack_in_service", 32'(InService), 32'b001);
        check("ack_pending", 32'(Pending), 32'b000);
        check("ack_exp_req", 32'(ExpReq), 32'd0);

        // Nesting.
        IrqIn = 3'b101;
        wait_req("nest_wait");
        check("nest_src", 32'(ExpSrc), 32'b100);
        pulse_ack();
        check("nest_is_101", 32'(InService), 32'b101);
        pulse_eret();
        check("nest_eret1", 32'(InService), 32'b001);
        pulse_eret();
        check("nest_eret2", 32'(InService), 32'b000);
        pulse_eret();
        check("nest_eret3", 32'(InService), 32'b000);
        check("nest_no_req", 32'(ExpReq), 32'd0);

        // Simultaneous requests.
        IrqIn = 3'b000;
        idle(4);
        IrqIn = 3'b101;
        wait_req("simul_wait");
        check("simul_src", 32'(ExpSrc), 32'b100);
        pulse_ack();
        check("simul_pending", 32'(Pending), 32'b001);
        idle(3);
        check("simul_blocked", 32'(ExpReq), 32'd0);
        Eret = 1'b1;
        @(negedge clk);
        Eret = 1'b0;
        check("simul_eret_gap", 32'(ExpReq), 32'd0);
        idle(1);
        check("simul_eret_req", 32'(ExpReq), 32'd1);
        check("simul_eret_src", 32'(ExpSrc), 32'b001);
        pulse_ack();

        // Withdrawal and reissue.
        IrqIn = 3'b111;
        wait_req("wd_wait");
        check("wd_src", 32'(ExpSrc), 32'b010);
        IrqMask = 3'b101;
        idle(1);
        check("wd_req", 32'(ExpReq), 32'd0);
        check("wd_pending", 32'(Pending), 32'b010);
        IrqMask = 3'b111;
        wait_req("wd_reissue");
        check("wd_reissue_src", 32'(ExpSrc), 32'b010);
        pulse_ack();
        check("wd_is", 32'(InService), 32'b011);
        pulse_eret();
        pulse_eret();
        check("wd_is_clear", 32'(InService), 32'b000);

        // Ack colliding with a new edge of the same source.
        IrqIn = 3'b000;
        idle(4);
        IrqIn = 3'b100;
        wait_req("col_wait");
        IrqIn = 3'b000;
        idle(1);
        IrqIn = 3'b100;
        idle(2);
        pulse_ack();
        check("col_pending", 32'(Pending), 32'b100);
        check("col_is", 32'(InService), 32'b100);
        pulse_eret();
        wait_req("col_rereq");
        check("col_rereq_src", 32'(ExpSrc), 32'b100);
        pulse_ack();
        pulse_eret();

        // Eret and Ack in the same cycle.
        IrqIn = 3'b110;
        wait_req("ea_wait1");
        check("ea_src1", 32'(ExpSrc), 32'b010);
        pulse_ack();
        IrqIn = 3'b010;
        idle(1);
        IrqIn = 3'b110;
        wait_req("ea_wait2");
        check("ea_src2", 32'(ExpSrc), 32'b100);
        Eret = 1'b1;
        Ack  = 1'b1;
        @(negedge clk);
        Eret = 1'b0;
        Ack  = 1'b0;
        check("ea_is", 32'(InService), 32'b100);
        pulse_eret();
        check("ea_is_clear", 32'(InService), 32'b000);

        // Asynchronous reset in REQ.
        IrqIn = 3'b000;
        idle(4);
        IrqIn = 3'b010;
        wait_req("ar_wait");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_exp_req", 32'(ExpReq), 32'd0);
        check("ar_exp_src", 32'(ExpSrc), 32'd0);
        check("ar_pending", 32'(Pending), 32'd0);
        check("ar_in_service", 32'(InService), 32'd0);
        idle(2);
        rst = 1'b0;
        wait_req("ar_after");
        check("ar_after_src", 32'(ExpSrc), 32'b010);
        pulse_ack();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                idx = int'($urandom_range(0, N - 1));
                IrqIn[idx] = ~IrqIn[idx];
            end
            IrqMask     = ($urandom_range(0, 15) == 0) ? N'($urandom) : 3'b111;
            GlobalBlock = ($urandom_range(0, 15) == 0);
            Ack         = ($urandom_range(0, 2) == 0);
            Eret        = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        IrqMask     = 3'b111;
        GlobalBlock = 1'b0;
        Ack         = 1'b0;
        Eret        = 1'b0;
        idle(10);

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
